// File: rtl/chnlnk_evt_sched_if.sv
// Bundles the trigger, frame-state and status signals exchanged with the event scheduler.
// Optional ERR_CNT signal exists only when CHNLNK_SCHED_ERR_EN is defined.
interface chnlnk_evt_sched_if;
    logic       l1a;
    logic [4:0] nsamp;
    logic [2:0] frm_state;
    logic       l1a_buf_mt;
    logic       end_evt;
    logic [3:0] evt_cnt;
    logic [4:0] samp_cnt;
    logic       busy;
    logic       ovfl;
`ifdef CHNLNK_SCHED_ERR_EN
    logic [7:0] err_cnt;
`endif

    modport master (
        output l1a, nsamp, frm_state,
`ifdef CHNLNK_SCHED_ERR_EN
        input  err_cnt,
`endif
        input  l1a_buf_mt, end_evt, evt_cnt, samp_cnt, busy, ovfl
    );

    modport slave (
        input  l1a, nsamp, frm_state,
`ifdef CHNLNK_SCHED_ERR_EN
        output err_cnt,
`endif
        output l1a_buf_mt, end_evt, evt_cnt, samp_cnt, busy, ovfl
    );
endinterface

// File: rtl/chnlnk_evt_sched.sv
// Channel-link event scheduler: counts pending L1A triggers and tracks samples of the event
// being read out by the frame FSM. Optional protocol error counter: CHNLNK_SCHED_ERR_EN.
module chnlnk_evt_sched (
    input logic               clk,
    input logic               rst,
    chnlnk_evt_sched_if.slave bus
);
    localparam logic [2:0] FS_IDLE        = 3'd0;
    localparam logic [2:0] FS_LAST_WORD   = 3'd1;
    localparam logic [2:0] FS_TAIL_END    = 3'd4;
    localparam logic [2:0] FS_TAIL_NO_END = 3'd5;
    localparam logic [2:0] FS_W4DATA      = 3'd6;
    localparam logic [2:0] FS_ILLEGAL     = 3'd7;

    typedef enum logic {S_IDLE, S_EVT} state_t;

    state_t     state_q, state_d;
    logic [2:0] prev_state;
    logic [4:0] samp_cnt_q, samp_cnt_d;
    logic [4:0] nsamp_lat_q, nsamp_lat_d;
    logic [3:0] evt_cnt_q, evt_cnt_d;
    logic       ovfl_q, ovfl_d;

    logic ent_last_word, ent_tail_end, ent_tail_no_end, ent_w4data, illegal, last_samp;

    assign ent_last_word   = (bus.frm_state == FS_LAST_WORD)   && (prev_state != FS_LAST_WORD);
    assign ent_tail_end    = (bus.frm_state == FS_TAIL_END)    && (prev_state != FS_TAIL_END);
    assign ent_tail_no_end = (bus.frm_state == FS_TAIL_NO_END) && (prev_state != FS_TAIL_NO_END);
    assign ent_w4data      = (bus.frm_state == FS_W4DATA)      && (prev_state == FS_IDLE);
    assign illegal         = (bus.frm_state == FS_ILLEGAL);
    assign last_samp       = (samp_cnt_q == nsamp_lat_q - 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_state  <= FS_IDLE;
            samp_cnt_q  <= '0;
            nsamp_lat_q <= 5'd1;
            evt_cnt_q   <= '0;
            ovfl_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_state  <= bus.frm_state;
            samp_cnt_q  <= samp_cnt_d;
            nsamp_lat_q <= nsamp_lat_d;
            evt_cnt_q   <= evt_cnt_d;
            ovfl_q      <= ovfl_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        nsamp_lat_d = nsamp_lat_q;
        // An illegal frame code aborts the event regardless of scheduler state.
        if (illegal) begin
            state_d    = S_IDLE;
            samp_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ent_w4data) begin
                        state_d     = S_EVT;
                        nsamp_lat_d = (bus.nsamp == 5'd0) ? 5'd1 : bus.nsamp;
                        samp_cnt_d  = '0;
                    end
                end
                S_EVT: begin
                    if (ent_last_word) begin
                        state_d    = S_IDLE;
                        samp_cnt_d = '0;
                    end else if (ent_tail_no_end && (samp_cnt_q != 5'd31)) begin
                        samp_cnt_d = samp_cnt_q + 5'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A trigger coinciding with a readout completion is always accepted, even when full.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        ovfl_d    = ovfl_q;
        if (bus.l1a && !ent_last_word) begin
            if (evt_cnt_q == 4'd15) ovfl_d = 1'b1;
            else                    evt_cnt_d = evt_cnt_q + 4'd1;
        end else if (!bus.l1a && ent_last_word) begin
            if (evt_cnt_q != 4'd0) evt_cnt_d = evt_cnt_q - 4'd1;
        end
    end

    assign bus.l1a_buf_mt = (evt_cnt_q == 4'd0);
    assign bus.end_evt    = (state_q == S_EVT) && last_samp;
    assign bus.evt_cnt    = evt_cnt_q;
    assign bus.samp_cnt   = samp_cnt_q;
    assign bus.busy       = (state_q == S_EVT);
    assign bus.ovfl       = ovfl_q;

`ifdef CHNLNK_SCHED_ERR_EN
    logic [7:0] err_cnt_q;
    logic       err_hit;

    assign err_hit = (ent_last_word && (state_q == S_IDLE)) || illegal ||
                     (ent_tail_end && !last_samp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            err_cnt_q <= '0;
        else if (err_hit && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_chnlnk_evt_sched.sv
// Self-checking bench for chnlnk_evt_sched: directed scenarios plus randomized frame/trigger
// traffic compared against a behavioural model. ERR_CNT checks only with CHNLNK_SCHED_ERR_EN.
module tb_chnlnk_evt_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    chnlnk_evt_sched_if bus();

    chnlnk_evt_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model of the scheduler's observable state.
    int  m_prev, m_samp, m_nsamp, m_evt, m_err;
    bit  m_busy, m_ovfl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_samp = 0; m_nsamp = 1; m_evt = 0; m_err = 0;
        m_busy = 0; m_ovfl = 0;
    endtask

    task automatic model_step(input bit l, input int n, input int f);
        bit lw, te, tne;
        lw  = (f == 1) && (m_prev != 1);
        te  = (f == 4) && (m_prev != 4);
        tne = (f == 5) && (m_prev != 5);
        if ((lw && !m_busy) || f == 7 || (te && m_samp != m_nsamp - 1))
            m_err = (m_err < 255) ? m_err + 1 : 255;
        if (l && !lw) begin
            if (m_evt == 15) m_ovfl = 1;
            else             m_evt++;
        end else if (lw && !l) begin
            if (m_evt > 0) m_evt--;
        end
        if (f == 7) begin
            m_busy = 0; m_samp = 0;
        end else if (!m_busy) begin
            if (f == 6 && m_prev == 0) begin
                m_busy = 1; m_samp = 0; m_nsamp = (n == 0) ? 1 : n;
            end
        end else if (lw) begin
            m_busy = 0; m_samp = 0;
        end else if (tne) begin
            m_samp = (m_samp < 31) ? m_samp + 1 : 31;
        end
        m_prev = f;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".buf_mt"},   bus.l1a_buf_mt, (m_evt == 0));
        chk({ctx, ".end_evt"},  bus.end_evt,    (m_busy && m_samp == m_nsamp - 1));
        chk({ctx, ".evt_cnt"},  bus.evt_cnt,    m_evt);
        chk({ctx, ".samp_cnt"}, bus.samp_cnt,   m_samp);
        chk({ctx, ".busy"},     bus.busy,       m_busy);
        chk({ctx, ".ovfl"},     bus.ovfl,       m_ovfl);
`ifdef CHNLNK_SCHED_ERR_EN
        chk({ctx, ".err_cnt"},  bus.err_cnt,    m_err);
`endif
    endtask

    // Called at posedge+1; drives inputs, advances one clock, checks at posedge+1.
    task automatic cycle(input string ctx, input bit l, input int n, input int f);
        bus.l1a       = l;
        bus.nsamp     = 5'(n);
        bus.frm_state = 3'(f);
        @(posedge clk);
        model_step(l, n, f);
        #1;
        check_outputs(ctx);
    endtask

    task automatic do_reset();
        bus.l1a = 1'b0; bus.nsamp = 5'd1; bus.frm_state = 3'd0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset");
    endtask

    int seq31 [] = '{0, 6, 3, 2, 2, 5, 3, 2, 5, 3, 2, 4, 1, 0};

    initial begin
        bus.l1a = 1'b0; bus.nsamp = 5'd1; bus.frm_state = 3'd0;
        model_reset();
        #1;
        check_outputs("async_reset");
        do_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) cycle("idle", 0, 1, 0);
        chk("idle_buf_mt", bus.l1a_buf_mt, 1);
        chk("idle_busy", bus.busy, 0);

        // Single NSAMP=3 event
        cycle("ev3", 1, 3, 0);
        chk("ev3_l1a_cnt", bus.evt_cnt, 1);
        foreach (seq31[i]) begin
            cycle("ev3", 0, 3, seq31[i]);
            if (i == 8) chk("ev3_end_after_2nd_tne", bus.end_evt, 1);
            if (i == 5) chk("ev3_end_after_1st_tne", bus.end_evt, 0);
            if (i == 12) begin
                chk("ev3_lw_cnt", bus.evt_cnt, 0);
                chk("ev3_lw_busy", bus.busy, 0);
            end
        end

        // Overflow at 15 and coincident accept
        do_reset();
        for (int i = 0; i < 16; i++) cycle("ovfl", 1, 1, 0);
        chk("ovfl_cnt15", bus.evt_cnt, 15);
        chk("ovfl_set", bus.ovfl, 1);
        do_reset();
        for (int i = 0; i < 15; i++) cycle("full", 1, 1, 0);
        cycle("full_coinc", 1, 1, 1);
        chk("coinc_cnt15", bus.evt_cnt, 15);
        chk("coinc_no_ovfl", bus.ovfl, 0);
        cycle("full_drain", 0, 1, 0);
        cycle("full_drain", 0, 1, 1);
        chk("drain_cnt14", bus.evt_cnt, 14);

        // NSAMP=0 event, NSAMP altered mid-event
        do_reset();
        cycle("ns0", 1, 0, 0);
        cycle("ns0", 0, 0, 6);
        cycle("ns0", 0, 0, 3);
        chk("ns0_end_strt", bus.end_evt, 1);
        cycle("ns0", 0, 5, 2);
        cycle("ns0", 0, 5, 2);
        chk("ns0_end_hold", bus.end_evt, 1);
        cycle("ns0", 0, 5, 4);
        cycle("ns0", 0, 5, 1);

        // Asynchronous reset mid-event with SAMP_CNT=2, EVT_CNT=4
        do_reset();
        for (int i = 0; i < 4; i++) cycle("mid", 1, 6, 0);
        cycle("mid", 0, 6, 6);
        for (int i = 0; i < 2; i++) begin
            cycle("mid", 0, 6, 3);
            cycle("mid", 0, 6, 5);
        end
        chk("mid_samp2", bus.samp_cnt, 2);
        chk("mid_evt4", bus.evt_cnt, 4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.frm_state = 3'd0;

`ifdef CHNLNK_SCHED_ERR_EN
        do_reset();
        cycle("err", 0, 1, 7);
        chk("err_ill_cnt", bus.err_cnt, 1);
        chk("err_ill_busy", bus.busy, 0);
        cycle("err", 0, 1, 0);
        cycle("err", 0, 1, 1);
        chk("err_lw_idle", bus.err_cnt, 2);
`endif

        // Randomized traffic
        do_reset();
        begin
            int f, n;
            bit l;
            f = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 99) < 40) begin
                    f = (($urandom_range(0, 99) < 3)) ? 7 : int'($urandom_range(0, 6));
                end
                l = ($urandom_range(0, 99) < 20);
                n = $urandom_range(0, 31);
                if (n > 6 && $urandom_range(0, 1) == 1) n = n % 5;
                cycle("rand", l, n, f);
                if ($urandom_range(0, 999) == 0) begin
                    #3;
                    rst = 1'b1;
                    model_reset();
                    #1;
                    check_outputs("rand_rst");
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    f = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/chnlnk_evt_sched.md
CHNLNK_EVT_SCHED -- requirements
Module: chnlnk_evt_sched

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-high.
REQ-003 L1A  input  1  one-cycle pulse; one accepted trigger awaiting frame readout.
REQ-004 NSAMP  input  5  samples per event, 1..31; value 0 treated as 1.
REQ-005 FRM_STATE  input  3  frame FSM state code: 0 Idle, 1 Last_Word, 2 Read, 3 Strt_Sample, 4 Tail_End, 5 Tail_No_End, 6 W4Data, 7 illegal.
REQ-006 L1A_BUF_MT  output  1  high when no pending events; drives frame FSM L1A_BUF_MT.
REQ-007 END_EVT  output  1  high while the current sample is the last of the event; drives frame FSM END_EVT.
REQ-008 EVT_CNT  output  4  pending event count, 0..15.
REQ-009 SAMP_CNT  output  5  samples completed in current event.
REQ-010 BUSY  output  1  high while scheduler FSM is in S_EVT.
REQ-011 OVFL  output  1  sticky; L1A dropped because EVT_CNT was 15.
REQ-012 ERR_CNT  output  8  protocol error count (present only with CHNLNK_SCHED_ERR_EN).

Function
REQ-013 Block SHALL register FRM_STATE into prev_state each cycle; "entry into X" means FRM_STATE==X and prev_state!=X.
REQ-014 Scheduler FSM SHALL have two states: S_IDLE, S_EVT.
REQ-015 S_IDLE -> S_EVT on entry into W4Data (6) with prev_state==Idle (0); same cycle latch nsamp_lat = (NSAMP==0 ? 1 : NSAMP), clear SAMP_CNT.
REQ-016 S_EVT -> S_IDLE on entry into Last_Word (1); same cycle clear SAMP_CNT.
REQ-017 In S_EVT, entry into Tail_No_End (5) SHALL increment SAMP_CNT by 1, saturating at 31.
REQ-018 END_EVT SHALL be combinational: BUSY and SAMP_CNT == nsamp_lat-1; low in S_IDLE.
REQ-019 NSAMP changes while BUSY SHALL NOT affect the current event.
REQ-020 EVT_CNT: L1A alone +1; entry into Last_Word alone -1; both in same cycle -> unchanged.
REQ-021 EVT_CNT==15 with L1A and no decrement: count held, OVFL set; L1A with simultaneous decrement at 15 SHALL be accepted (net unchanged, OVFL not set).
REQ-022 EVT_CNT==0 with Last_Word entry: count held at 0 (no wrap).
REQ-023 L1A_BUF_MT SHALL equal (EVT_CNT==0), registered-count derived, no extra latency.
REQ-024 FRM_STATE==7 in any cycle SHALL force scheduler to S_IDLE and clear SAMP_CNT; EVT_CNT unaffected.

Reset
REQ-025 On RST: S_IDLE, prev_state=0, EVT_CNT=0, SAMP_CNT=0, nsamp_lat=1, OVFL=0, BUSY=0, ERR_CNT=0; hence L1A_BUF_MT=1, END_EVT=0.
REQ-026 RST asserted mid-event SHALL discard the event and all pending counts immediately (asynchronous).
REQ-027 OVFL and ERR_CNT SHALL clear only on RST.

Configuration
REQ-028 Macro CHNLNK_SCHED_ERR_EN defined: ERR_CNT port present, increments (saturating at 255) on entry into Last_Word while S_IDLE, on FRM_STATE==7, and on entry into Tail_End while SAMP_CNT != nsamp_lat-1.
REQ-029 Macro undefined: ERR_CNT port and logic absent; all other behaviour identical.

Verification
REQ-030 Reset then idle 10 cycles -> L1A_BUF_MT=1, END_EVT=0, EVT_CNT=0, BUSY=0.
REQ-031 NSAMP=3, one L1A, FRM_STATE sequence 0->6->(3,2..,5) x2 ->(3,2..,4)->1 -> END_EVT high only after second Tail_No_End entry, SAMP_CNT 0,1,2, EVT_CNT 1->0 at Last_Word, BUSY falls.
REQ-032 16 L1A pulses with no readout -> EVT_CNT=15, OVFL=1 after 16th; L1A coincident with Last_Word entry at 15 -> EVT_CNT stays 15, OVFL unchanged.
REQ-033 NSAMP=0, one event -> END_EVT high from first Strt_Sample (SAMP_CNT=0); NSAMP changed to 5 mid-event -> END_EVT unchanged.
REQ-034 RST pulsed while SAMP_CNT=2, EVT_CNT=4 -> all outputs at reset values same cycle.
REQ-035 With CHNLNK_SCHED_ERR_EN: FRM_STATE=7 one cycle -> ERR_CNT=1, BUSY=0; Last_Word entry in S_IDLE -> ERR_CNT=2.
